gate_switch_ctrl: RTL and testbench
===================================

# gate_switch_ctrl

Multi-channel successor to the single-switch gate open/close port. Each of `CHANNELS` raw switch inputs is synchronised, debounced and edge-qualified according to a per-channel edge mode. Every qualified edge toggles that channel's gate level. An optional interlock prevents more than one gate from being open at once. The block sits between the board switches and the lock/gate sequencing logic; one instance replaces all per-gate ports.

## Interface
- `CHANNELS`, default 2: number of independent switch/gate channels, ≥1.
- `DEBOUNCE`, default 4: consecutive stable synchronised samples required to accept a level change, 1..2^`DB_W`-1.
- `DB_W`, default 8: debounce counter width.

Ports:
- `Clock`  in  1  — sole clock; all logic on rising edge.
- `Reset`  in  1  — synchronous, active-high.
- `SwitchIn`  in  `CHANNELS`  — raw asynchronous switch levels.
- `EdgeMode`  in  2*`CHANNELS`  — per channel, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
- `EdgePulse`  out  `CHANNELS`  — one-cycle pulse per qualified edge.
- `OpenClose`  out  `CHANNELS`  — gate level, 1 = open.
- `Blocked`  out  `CHANNELS`  — one-cycle pulse when an open request is refused by the interlock.

## Operation
- Per channel: 2-flop synchroniser `s1`→`s2`, registered debounced level `stable`, counter `cnt[DB_W-1:0]`.
- Debounce, every cycle:
  - If `s2`==`stable`: `cnt`←0.
  - Else if `cnt`==`DEBOUNCE`-1: `stable`←`s2`, `cnt`←0, and raise a level-change event (rising if the new level is 1, falling if 0).
  - Else: `cnt`←`cnt`+1.
- A glitch shorter than `DEBOUNCE` samples resets `cnt`. `stable` is unchanged and no event is raised.
- Qualification: an event is qualified when `EdgeMode` for that channel selects its direction. `EdgeMode` is sampled in the event cycle only.
  - Mode 00: debouncer keeps tracking, but no pulse or toggle is produced.
- Qualified edge: `EdgePulse[i]`←1 for one cycle and `OpenClose[i]` toggles, subject to the interlock.
- Counter arithmetic never wraps. `cnt` cannot exceed `DEBOUNCE`-1.
- Reset value of every register is 0: `s1`, `s2`, `stable`, `cnt`, `EdgePulse`, `OpenClose`, `Blocked`.
- Reset mid-debounce discards the pending change.
- A switch held high through reset release is seen as a rising change, so a rising or both-mode channel toggles open after the normal latency.

## Timing
- Raw change is captured into `s1` at edge k and reaches `s2` at edge k+1.
- `stable`, `EdgePulse` and `OpenClose` update together at edge k+1+`DEBOUNCE`.
- `EdgePulse` and `Blocked` are high for exactly one cycle per event.
- Minimum spacing between events on one channel is `DEBOUNCE` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Channels are fully independent except through the interlock.

## Configuration
- `GATE_INTERLOCK_EN` defined:
  - A qualified edge that would take `OpenClose[i]` from 0→1 is refused if any other channel's registered `OpenClose` is 1.
  - On refusal: `OpenClose[i]` is held, `EdgePulse[i]` still pulses, and `Blocked[i]` pulses.
  - Several simultaneous open requests with all gates closed: the lowest index wins and the others are blocked.
  - Closing is always allowed.
  - A close on channel j and an open on channel i in the same cycle: the open is blocked, because decisions use registered values. It must be retried.
- `GATE_INTERLOCK_EN` undefined: `Blocked` is tied to 0 and every qualified edge toggles unconditionally.

## Test plan
- Reset, then raise `SwitchIn[0]` with mode 01 and `DEBOUNCE`=4 → `EdgePulse[0]` and `OpenClose[0]`=1 exactly 5 edges after the capturing edge. Lower it → no pulse, level stays 1.
- Mode 11: toggle `SwitchIn[1]` high, then low, 10 cycles apart → two pulses, and `OpenClose[1]` goes 0→1→0.
- A 3-cycle glitch high with `DEBOUNCE`=4 → no pulse, `stable` stays 0. A 4-cycle pulse → one event.
- Assert `Reset` 2 cycles into debounce → no event, all outputs 0. Switch still high after release → open after full latency.
- With `GATE_INTERLOCK_EN`: open ch0, then request an open on ch1 → `Blocked[1]` pulses, `OpenClose`=01. Close ch0, then request ch1 → `OpenClose`=10.
- With `GATE_INTERLOCK_EN`: simultaneous rising edges on ch0 and ch1, all closed → `OpenClose`=01 and `Blocked[1]` pulses. Without the macro → `OpenClose`=11 and `Blocked`=0.

Source files
------------

// File: rtl/gate_switch_ctrl.sv
// Multi-channel switch debouncer with per-channel edge qualification driving toggled gate levels.
// Optional single-open-gate interlock is built when GATE_INTERLOCK_EN is defined.
module gate_switch_ctrl #(
    parameter int CHANNELS = 2,
    parameter int DEBOUNCE = 4,
    parameter int DB_W     = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [CHANNELS-1:0]   SwitchIn,
    input  logic [2*CHANNELS-1:0] EdgeMode,
    output logic [CHANNELS-1:0]   EdgePulse,
    output logic [CHANNELS-1:0]   OpenClose,
    output logic [CHANNELS-1:0]   Blocked
);

    localparam logic [DB_W-1:0] LIMIT = DB_W'(DEBOUNCE - 1);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CHANNELS-1:0] stable;
    logic [DB_W-1:0]     cnt [CHANNELS];

    logic [CHANNELS-1:0] change;
    logic [CHANNELS-1:0] qual;
    logic [CHANNELS-1:0] refuse;

    // Saturating increment keeps the debounce counter from ever wrapping.
    function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + DB_W'(1);
    endfunction

    always_comb begin
        change = '0;
        qual   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            change[i] = (s2[i] != stable[i]) && (cnt[i] == LIMIT);
            qual[i]   = change[i] && (s2[i] ? EdgeMode[2*i] : EdgeMode[2*i+1]);
        end
    end

`ifdef GATE_INTERLOCK_EN
    logic [CHANNELS-1:0] open_req;

    // Decisions use registered gate levels; a same-cycle close elsewhere does not free the interlock.
    always_comb begin
        open_req = qual & ~OpenClose;
        refuse   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            refuse[i] = open_req[i] &&
                        ((|(OpenClose & ~(CHANNELS'(1) << i))) ||
                         (|(open_req & ((CHANNELS'(1) << i) - CHANNELS'(1)))));
        end
    end
`else
    always_comb refuse = '0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1        <= '0;
            s2        <= '0;
            stable    <= '0;
            EdgePulse <= '0;
            OpenClose <= '0;
            Blocked   <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            s1        <= SwitchIn;
            s2        <= s1;
            EdgePulse <= qual;
            OpenClose <= OpenClose ^ (qual & ~refuse);
            Blocked   <= refuse;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LIMIT) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_switch_ctrl.sv
// Directed bench for gate_switch_ctrl (CHANNELS=2, DEBOUNCE=4); expectations follow the build's interlock setting.
module tb_gate_switch_ctrl;

    logic       Clock;
    logic       Reset;
    logic [1:0] SwitchIn;
    logic [3:0] EdgeMode;
    logic [1:0] EdgePulse;
    logic [1:0] OpenClose;
    logic [1:0] Blocked;

    int checks = 0;
    int errors = 0;

    gate_switch_ctrl #(.CHANNELS(2), .DEBOUNCE(4), .DB_W(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .SwitchIn (SwitchIn),
        .EdgeMode (EdgeMode),
        .EdgePulse(EdgePulse),
        .OpenClose(OpenClose),
        .Blocked  (Blocked)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
        end
    endtask

`ifdef GATE_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    logic [1:0] seen;

    initial begin
        Reset    = 1'b1;
        SwitchIn = 2'b00;
        EdgeMode = 4'b0000;
        tick(3);
        chk("rst_pulse", 32'(EdgePulse), 32'h0);
        chk("rst_open",  32'(OpenClose), 32'h0);
        chk("rst_blk",   32'(Blocked),   32'h0);
        Reset = 1'b0;
        tick(1);

        // ch1 in both-edge mode: open then close
        EdgeMode = 4'b1101;
        SwitchIn = 2'b10;
        tick(5);
        chk("ch1_rise_early", 32'(EdgePulse), 32'h0);
        tick(1);
        chk("ch1_rise_pulse", 32'(EdgePulse), 32'h2);
        chk("ch1_rise_open",  32'(OpenClose), 32'h2);
        tick(1);
        chk("ch1_pulse_1cyc", 32'(EdgePulse), 32'h0);
        tick(3);
        SwitchIn = 2'b00;
        tick(5);
        chk("ch1_fall_early", 32'(OpenClose), 32'h2);
        tick(1);
        chk("ch1_fall_pulse", 32'(EdgePulse), 32'h2);
        chk("ch1_fall_close", 32'(OpenClose), 32'h0);
        tick(4);

        // 3-cycle glitch on ch0 must be rejected
        SwitchIn = 2'b01;
        tick(3);
        SwitchIn = 2'b00;
        seen = 2'b00;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            seen = seen | EdgePulse;
        end
        chk("glitch_pulse", 32'(seen),      32'h0);
        chk("glitch_open",  32'(OpenClose), 32'h0);

        // 4-cycle pulse on ch0 (rising mode) opens it; the fall is ignored
        SwitchIn = 2'b01;
        tick(4);
        SwitchIn = 2'b00;
        tick(1);
        chk("p4_early", 32'(EdgePulse), 32'h0);
        tick(1);
        chk("p4_pulse", 32'(EdgePulse), 32'h1);
        chk("p4_open",  32'(OpenClose), 32'h1);
        seen = 2'b00;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            seen = seen | EdgePulse;
        end
        chk("p4_fall_nopulse", 32'(seen),      32'h0);
        chk("p4_fall_hold",    32'(OpenClose), 32'h1);

        // open request on ch1 while ch0 is open
        SwitchIn = 2'b10;
        tick(6);
        chk("req1_pulse", 32'(EdgePulse), 32'h2);
        chk("req1_blk",   32'(Blocked),   IL ? 32'h2 : 32'h0);
        chk("req1_open",  32'(OpenClose), IL ? 32'h1 : 32'h3);
        tick(1);
        chk("req1_blk_1cyc", 32'(Blocked), 32'h0);

        // close ch0 (both-edge mode now), then retry ch1
        EdgeMode = 4'b1111;
        SwitchIn = 2'b11;
        tick(6);
        chk("close0_pulse", 32'(EdgePulse), 32'h1);
        chk("close0_open",  32'(OpenClose), IL ? 32'h0 : 32'h2);
        tick(2);
        SwitchIn = 2'b01;
        tick(6);
        chk("retry1_pulse", 32'(EdgePulse), 32'h2);
        chk("retry1_open",  32'(OpenClose), IL ? 32'h2 : 32'h0);
        chk("retry1_blk",   32'(Blocked),   32'h0);
        tick(4);

        // reset mid-debounce, switches held high through release
        EdgeMode = 4'b1101;
        SwitchIn = 2'b11;
        tick(3);
        Reset = 1'b1;
        tick(2);
        chk("midrst_pulse", 32'(EdgePulse), 32'h0);
        chk("midrst_open",  32'(OpenClose), 32'h0);
        chk("midrst_blk",   32'(Blocked),   32'h0);
        Reset = 1'b0;
        tick(5);
        chk("rel_early", 32'(EdgePulse), 32'h0);
        tick(1);
        chk("sim_pulse", 32'(EdgePulse), 32'h3);
        chk("sim_open",  32'(OpenClose), IL ? 32'h1 : 32'h3);
        chk("sim_blk",   32'(Blocked),   IL ? 32'h2 : 32'h0);
        tick(1);
        chk("sim_pulse_end", 32'(EdgePulse), 32'h0);
        chk("sim_blk_end",   32'(Blocked),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
